// File: rtl/cellrv32_package.sv
// Shared types and helpers for the vector reduction tree.
package cellrv32_package;

    localparam int unsigned RDC_OP_W   = 3;
    localparam int unsigned RDC_MAX_DW = 64;

    localparam logic [RDC_OP_W-1:0] RDC_OP_SUM  = 3'd0;
    localparam logic [RDC_OP_W-1:0] RDC_OP_AND  = 3'd1;
    localparam logic [RDC_OP_W-1:0] RDC_OP_OR   = 3'd2;
    localparam logic [RDC_OP_W-1:0] RDC_OP_XOR  = 3'd3;
    localparam logic [RDC_OP_W-1:0] RDC_OP_MINU = 3'd4;
    localparam logic [RDC_OP_W-1:0] RDC_OP_MIN  = 3'd5;
    localparam logic [RDC_OP_W-1:0] RDC_OP_MAXU = 3'd6;
    localparam logic [RDC_OP_W-1:0] RDC_OP_MAX  = 3'd7;

    typedef enum logic [RDC_OP_W-1:0] {
        RDC_SUM  = RDC_OP_SUM,
        RDC_AND  = RDC_OP_AND,
        RDC_OR   = RDC_OP_OR,
        RDC_XOR  = RDC_OP_XOR,
        RDC_MINU = RDC_OP_MINU,
        RDC_MIN  = RDC_OP_MIN,
        RDC_MAXU = RDC_OP_MAXU,
        RDC_MAX  = RDC_OP_MAX
    } rdc_op_e;

    // Identity element of op at width dw (dw <= RDC_MAX_DW), right-aligned.
    function automatic logic [RDC_MAX_DW-1:0] rdc_identity(input rdc_op_e op, input int unsigned dw);
        logic [RDC_MAX_DW-1:0] ones;
        ones = {RDC_MAX_DW{1'b1}} >> (RDC_MAX_DW - dw);
        case (op)
            RDC_AND, RDC_MINU: return ones;
            RDC_MIN:           return ones >> 1;
            RDC_MAX:           return RDC_MAX_DW'(1) << (dw - 1);
            default:           return '0;
        endcase
    endfunction

    // Offset of tree level k (k >= 1) inside the flat node register array.
    function automatic int unsigned rdc_lvl_off(input int unsigned lanes, input int unsigned k);
        return lanes - 2 * (lanes >> k);
    endfunction

endpackage

// File: rtl/vex_rdc_alu.sv
// Two-operand combine for one reduction node or the accumulator.
module vex_rdc_alu
    import cellrv32_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  rdc_op_e               op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] y_o
);

    always_comb begin
        y_o = a_i;
        unique case (op_i)
            RDC_SUM:  y_o = a_i + b_i;
            RDC_AND:  y_o = a_i & b_i;
            RDC_OR:   y_o = a_i | b_i;
            RDC_XOR:  y_o = a_i ^ b_i;
            RDC_MINU: y_o = (a_i < b_i) ? a_i : b_i;
            RDC_MIN:  y_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
            RDC_MAXU: y_o = (a_i > b_i) ? a_i : b_i;
            RDC_MAX:  y_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
        endcase
    end

endmodule

// File: rtl/vex_rdc_tree.sv
// Pipelined masked vector reduction tree with cross-micro-op accumulator.
module vex_rdc_tree
    import cellrv32_package::*;
#(
    parameter int unsigned VECTOR_LANES     = 8,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned VECTOR_REGISTERS = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [2:0]                          op_i,
    input  logic [VECTOR_LANES-1:0]             mask_i,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0]  data_i,
    input  logic [DATA_WIDTH-1:0]               seed_i,
    input  logic [$clog2(VECTOR_REGISTERS)-1:0] dst_i,
    input  logic                                head_uop_i,
    input  logic                                end_uop_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [DATA_WIDTH-1:0]               result_o,
    output logic [$clog2(VECTOR_REGISTERS)-1:0] dst_o,
    output logic                                busy_o
);

    localparam int unsigned S     = $clog2(VECTOR_LANES);
    localparam int unsigned NODES = VECTOR_LANES - 1;
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned DST_W = $clog2(VECTOR_REGISTERS);

    rdc_op_e         op_e;
    logic            hold;
    logic [DW-1:0]   lane_m [VECTOR_LANES];
    logic [DW-1:0]   ident;

    logic [DW-1:0]   node_d [NODES];
    logic [DW-1:0]   node_q [NODES];

    logic [S-1:0]    vld_q;
    logic [S-1:0]    head_q;
    logic [S-1:0]    end_q;
    rdc_op_e         op_q   [S];
    logic [DST_W-1:0] dst_q [S];
    logic [DW-1:0]   seed_q [S];

    logic [DW-1:0]   acc_q;
    logic [DW-1:0]   acc_d;
    logic [DW-1:0]   acc_a;
    logic            valid_q;
    logic [DW-1:0]   result_q;
    logic [DST_W-1:0] dst_o_q;

    assign op_e    = rdc_op_e'(op_i);
    assign hold    = valid_q & ~ready_i;
    assign ready_o = ~hold;
    assign busy_o  = (|vld_q) | valid_q;

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign dst_o    = dst_o_q;

    // Inactive lanes become the identity so they drop out of the fold.
    always_comb begin
        ident = DW'(rdc_identity(op_e, DW));
        for (int i = 0; i < VECTOR_LANES; i++) begin
            lane_m[i] = mask_i[i] ? data_i[i*DW +: DW] : ident;
        end
    end

    for (genvar k = 1; k <= S; k++) begin : g_lvl
        localparam int unsigned OFF = rdc_lvl_off(VECTOR_LANES, k);
        rdc_op_e lvl_op;

        if (k == 1) begin : g_op
            assign lvl_op = op_e;
        end else begin : g_op
            assign lvl_op = op_q[k-2];
        end

        for (genvar j = 0; j < (VECTOR_LANES >> k); j++) begin : g_node
            logic [DW-1:0] a;
            logic [DW-1:0] b;

            if (k == 1) begin : g_in
                assign a = lane_m[2*j];
                assign b = lane_m[2*j+1];
            end else begin : g_in
                localparam int unsigned POFF = rdc_lvl_off(VECTOR_LANES, k - 1);
                assign a = node_q[POFF + 2*j];
                assign b = node_q[POFF + 2*j + 1];
            end

            vex_rdc_alu #(.DATA_WIDTH(DW)) u_alu (
                .op_i (lvl_op),
                .a_i  (a),
                .b_i  (b),
                .y_o  (node_d[OFF + j])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!hold) begin
            node_q <= node_d;
        end
    end

    // Sideband travels in lockstep with the tree data; only valids reset.
    always_ff @(posedge clk) begin
        if (!hold) begin
            op_q[0]   <= op_e;
            dst_q[0]  <= dst_i;
            seed_q[0] <= seed_i;
            head_q[0] <= head_uop_i;
            end_q[0]  <= end_uop_i;
            for (int k = 1; k < S; k++) begin
                op_q[k]   <= op_q[k-1];
                dst_q[k]  <= dst_q[k-1];
                seed_q[k] <= seed_q[k-1];
                head_q[k] <= head_q[k-1];
                end_q[k]  <= end_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (!hold) begin
            vld_q[0] <= valid_i;
            for (int k = 1; k < S; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign acc_a = head_q[S-1] ? seed_q[S-1] : acc_q;

    vex_rdc_alu #(.DATA_WIDTH(DW)) u_acc_alu (
        .op_i (op_q[S-1]),
        .a_i  (acc_a),
        .b_i  (node_q[NODES-1]),
        .y_o  (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            dst_o_q  <= '0;
        end else if (!hold) begin
            if (vld_q[S-1]) begin
                acc_q <= acc_d;
            end
            valid_q <= vld_q[S-1] & end_q[S-1];
            if (vld_q[S-1] && end_q[S-1]) begin
                result_q <= acc_d;
                dst_o_q  <= dst_q[S-1];
            end
        end
    end

endmodule

// File: tb/tb_vex_rdc_tree.sv
// Directed self-checking bench for vex_rdc_tree at 8 lanes x 32 bits.
module tb_vex_rdc_tree;

    localparam int unsigned L  = 8;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [L-1:0]    mask_i;
    logic [L*DW-1:0] data_i;
    logic [DW-1:0]   seed_i;
    logic [4:0]      dst_i;
    logic            head_uop_i;
    logic            end_uop_i;
    logic            valid_o;
    logic            ready_i;
    logic [DW-1:0]   result_o;
    logic [4:0]      dst_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chain_open = 0;
    bit vo_seen = 0;

    logic [DW-1:0] q_res [$];
    logic [4:0]    q_dst [$];
    int            q_cyc [$];

    vex_rdc_tree #(.VECTOR_LANES(L), .DATA_WIDTH(DW), .VECTOR_REGISTERS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .mask_i     (mask_i),
        .data_i     (data_i),
        .seed_i     (seed_i),
        .dst_i      (dst_i),
        .head_uop_i (head_uop_i),
        .end_uop_i  (end_uop_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .dst_o      (dst_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Completed output handshakes, with the cycle they completed in.
    always @(posedge clk) begin
        if (!rst && valid_o && ready_i) begin
            q_res.push_back(result_o);
            q_dst.push_back(dst_o);
            q_cyc.push_back(cyc);
        end
        if (valid_o) vo_seen <= 1'b1;
    end

    // A non-head micro-op must continue an open chain.
    always @(posedge clk) begin
        if (rst) begin
            chain_open <= 1'b0;
        end else if (valid_i && ready_o) begin
            if (!head_uop_i && !chain_open) $error("FAIL chain: non-head micro-op without open chain");
            chain_open <= !end_uop_i;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] m, input logic [255:0] d,
                         input logic [31:0] s, input logic [4:0] ds, input logic h, input logic e,
                         output int a);
        bit ok;
        ok = 0;
        a = 0;
        op_i = op; mask_i = m; data_i = d; seed_i = s; dst_i = ds;
        head_uop_i = h; end_uop_i = e; valid_i = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = ready_o;
            a = cyc;
            @(posedge clk);
        end
        #1;
        valid_i = 1'b0;
        if (!ok) begin
            $display("FAIL issue: micro-op never accepted");
            $fatal(1);
        end
    endtask

    function automatic logic [255:0] fill(input logic [31:0] v);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = v;
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; op_i = '0; mask_i = '0; data_i = '0;
        seed_i = '0; dst_i = '0; head_uop_i = 1'b0; end_uop_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result_o); end
        checks++; if (dst_o !== 5'd0) begin errors++; $display("FAIL reset_dst got %0d exp 0", dst_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_sum();
        logic [255:0] d;
        int a;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(i + 1);
        q_res.delete(); q_dst.delete(); q_cyc.delete();
        issue(3'd0, 8'hFF, d, 32'd10, 5'd5, 1'b1, 1'b1, a);
        for (int c = 0; c < 20 && q_res.size() < 1; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q_res.size() != 1) begin
            errors++; $display("FAIL sum_count got %0d exp 1", q_res.size());
        end else begin
            checks++; if (q_res[0] !== 32'd46) begin errors++; $display("FAIL sum_result got %0d exp 46", q_res[0]); end
            checks++; if (q_dst[0] !== 5'd5) begin errors++; $display("FAIL sum_dst got %0d exp 5", q_dst[0]); end
            checks++; if (q_cyc[0] - a != 4) begin errors++; $display("FAIL sum_latency got %0d exp 4", q_cyc[0] - a); end
        end
    endtask

    task automatic test_minmax();
        logic [255:0] d;
        logic [31:0] v [8];
        logic [31:0] exp_r [3];
        int a;
        v = '{32'hFFFF_FFFB, 32'd3, 32'd7, 32'd2, 32'd9, 32'd4, 32'd1, 32'd6};
        exp_r = '{32'd1, 32'd1, 32'hFFFF_FFFB};
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = v[i];
        q_res.delete(); q_dst.delete(); q_cyc.delete();
        issue(3'd5, 8'hFE, d, 32'd100, 5'd1, 1'b1, 1'b1, a);
        issue(3'd4, 8'hFF, d, 32'd100, 5'd2, 1'b1, 1'b1, a);
        issue(3'd6, 8'hFF, d, 32'd100, 5'd3, 1'b1, 1'b1, a);
        for (int c = 0; c < 20 && q_res.size() < 3; c++) @(posedge clk);
        #1;
        checks++;
        if (q_res.size() != 3) begin
            errors++; $display("FAIL minmax_count got %0d exp 3", q_res.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_res[i] !== exp_r[i]) begin errors++; $display("FAIL minmax_result[%0d] got %h exp %h", i, q_res[i], exp_r[i]); end
            end
            checks++; if (q_cyc[2] - q_cyc[0] != 2) begin errors++; $display("FAIL minmax_throughput got %0d exp 2", q_cyc[2] - q_cyc[0]); end
        end
    endtask

    task automatic test_all_masked();
        int a;
        q_res.delete(); q_dst.delete(); q_cyc.delete();
        issue(3'd1, 8'h00, fill(32'd0), 32'h1234, 5'd2, 1'b1, 1'b1, a);
        issue(3'd7, 8'h00, fill(32'd5), 32'hFFFF_FFFD, 5'd3, 1'b1, 1'b1, a);
        for (int c = 0; c < 20 && q_res.size() < 2; c++) @(posedge clk);
        #1;
        checks++;
        if (q_res.size() != 2) begin
            errors++; $display("FAIL masked_count got %0d exp 2", q_res.size());
        end else begin
            checks++; if (q_res[0] !== 32'h1234) begin errors++; $display("FAIL masked_and got %h exp 00001234", q_res[0]); end
            checks++; if (q_res[1] !== 32'hFFFF_FFFD) begin errors++; $display("FAIL masked_max got %h exp fffffffd", q_res[1]); end
        end
    endtask

    task automatic test_multi_uop();
        int a;
        q_res.delete(); q_dst.delete(); q_cyc.delete();
        issue(3'd0, 8'hFF, fill(32'd2), 32'd1,  5'd7, 1'b1, 1'b0, a);
        issue(3'd0, 8'hFF, fill(32'd2), 32'd99, 5'd7, 1'b0, 1'b0, a);
        issue(3'd0, 8'hFF, fill(32'd2), 32'd99, 5'd7, 1'b0, 1'b1, a);
        for (int c = 0; c < 20 && q_res.size() < 1; c++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q_res.size() != 1) begin
            errors++; $display("FAIL multi_count got %0d exp 1", q_res.size());
        end else begin
            checks++; if (q_res[0] !== 32'd49) begin errors++; $display("FAIL multi_result got %0d exp 49", q_res[0]); end
            checks++; if (q_cyc[0] - a != 4) begin errors++; $display("FAIL multi_latency got %0d exp 4", q_cyc[0] - a); end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] d;
        logic [31:0] exp_r [3];
        logic [4:0]  exp_d [3];
        int a;
        bit seen;
        exp_r = '{32'd8, 32'd255, 32'h1FF};
        exp_d = '{5'd1, 5'd2, 5'd3};
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(1) << i;
        q_res.delete(); q_dst.delete(); q_cyc.delete();
        ready_i = 1'b0;
        issue(3'd0, 8'hFF, fill(32'd1), 32'd0, 5'd1, 1'b1, 1'b1, a);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            seen = valid_o;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_pending got valid_o=0 exp 1"); end
        op_i = 3'd3; mask_i = 8'hFF; data_i = d; seed_i = 32'd0; dst_i = 5'd2;
        head_uop_i = 1'b1; end_uop_i = 1'b1; valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", c, ready_o); end
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", c, valid_o); end
            checks++; if (result_o !== 32'd8) begin errors++; $display("FAIL bp_stable[%0d] got %0d exp 8", c, result_o); end
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        issue(3'd3, 8'hFF, d, 32'd0, 5'd2, 1'b1, 1'b1, a);
        issue(3'd2, 8'hFF, d, 32'h100, 5'd3, 1'b1, 1'b1, a);
        for (int c = 0; c < 20 && q_res.size() < 3; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q_res.size() != 3) begin
            errors++; $display("FAIL bp_count got %0d exp 3", q_res.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (q_res[i] !== exp_r[i]) begin errors++; $display("FAIL bp_result[%0d] got %h exp %h", i, q_res[i], exp_r[i]); end
                checks++; if (q_dst[i] !== exp_d[i]) begin errors++; $display("FAIL bp_dst[%0d] got %0d exp %0d", i, q_dst[i], exp_d[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int a;
        q_res.delete(); q_dst.delete(); q_cyc.delete();
        vo_seen = 0;
        issue(3'd0, 8'hFF, fill(32'd4), 32'd0, 5'd4, 1'b1, 1'b1, a);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", valid_o); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (vo_seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_output got valid_o seen exp none"); end
        issue(3'd0, 8'hFF, fill(32'd3), 32'd7, 5'd9, 1'b1, 1'b1, a);
        for (int c = 0; c < 20 && q_res.size() < 1; c++) @(posedge clk);
        #1;
        checks++;
        if (q_res.size() != 1) begin
            errors++; $display("FAIL rstmid_count got %0d exp 1", q_res.size());
        end else begin
            checks++; if (q_res[0] !== 32'd31) begin errors++; $display("FAIL rstmid_result got %0d exp 31", q_res[0]); end
            checks++; if (q_dst[0] !== 5'd9) begin errors++; $display("FAIL rstmid_dst got %0d exp 9", q_dst[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_minmax();
        test_all_masked();
        test_multi_uop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vex_rdc_tree.md
# vex_rdc_tree

Parametrised, fully pipelined vector reduction tree for the vector execution stage. It folds VECTOR_LANES masked element values into one scalar with a selectable reduction operation, and accumulates across the micro-ops of one reduction instruction. It supports any power-of-two lane count and adds valid/ready backpressure and identity-element masking. It sits beside the vex_pipe lanes and delivers the scalar result plus destination register to writeback.

## Interface
Parameters:
- VECTOR_LANES, 8, lane count; power of two, 2..32
- DATA_WIDTH, 32, element width in bits
- VECTOR_REGISTERS, 32, register count; sets the dst width to $clog2(VECTOR_REGISTERS)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- valid_i  in  1  micro-op offered
- ready_o  out  1  micro-op accepted when valid_i & ready_o
- op_i  in  3  reduction op, equal to funct6[2:0]: 0 sum, 1 and, 2 or, 3 xor, 4 minu, 5 min, 6 maxu, 7 max
- mask_i  in  VECTOR_LANES  lane active bits
- data_i  in  VECTOR_LANES×DATA_WIDTH  element values
- seed_i  in  DATA_WIDTH  scalar seed (vs1[0]); used only on head micro-op
- dst_i  in  $clog2(VECTOR_REGISTERS)  destination register
- head_uop_i / end_uop_i  in  1 each  first / last micro-op of the instruction
- valid_o  out  1  result valid
- ready_i  in  1  writeback accepts result
- result_o  out  DATA_WIDTH  reduced scalar
- dst_o  out  $clog2(VECTOR_REGISTERS)  destination of result
- busy_o  out  1  any stage valid, or valid_o

## Operation
- S = log2(VECTOR_LANES) tree levels. op, dst, head and end travel with the data through every level.
- Masking: each lane with mask_i=0 is replaced by the identity of op before level 1.
  - 0 for sum, or, xor, maxu
  - all-ones for and, minu
  - signed maximum (0x7FFF_FFFF at DATA_WIDTH=32) for min
  - signed minimum (0x8000_0000 at DATA_WIDTH=32) for max
- Level k register holds VECTOR_LANES/2^k values. Node j of level k combines nodes 2j and 2j+1 of level k-1.
- Sum wraps modulo 2^DATA_WIDTH. min/max compare signed; minu/maxu compare unsigned.
- Accumulator stage, applied when level S is valid:
  - head: acc = op(seed, tree)
  - otherwise: acc = op(acc, tree)
  - The seed is captured at accept and carried along the pipe.
- If end is set, result_o = new acc, dst_o = carried dst, and valid_o sets. Non-end micro-ops update acc only and produce no output.
- op is constant within one head..end chain. A non-head micro-op with no open chain is illegal (bench assertion); its result is undefined.
- Back-to-back chains are legal; a head micro-op may follow an end micro-op in the next cycle.

## Timing
- Latency: accept at edge t gives level 1 valid in cycle t+1, level S in t+S, and valid_o in t+S+1 for an end micro-op. For VECTOR_LANES=8 the latency is 4 cycles.
- Throughput: one micro-op per cycle when not stalled.
- Stall: hold = valid_o & ~ready_i.
  - While hold is set, every pipeline register, acc and the outputs freeze, and ready_o=0.
  - ready_o = ~hold is a combinational path from ready_i.
  - result_o and dst_o stay stable while valid_o=1 and ready_i=0.
- Output completes when valid_o & ready_i. valid_o clears the next cycle unless a new end result arrives in the same cycle, in which case it stays 1 with the new value.
- Reset (takes effect at the next clk edge, also mid-operation):
  - all stage valids = 0, acc = 0, valid_o = 0, result_o = 0, dst_o = 0, busy_o = 0, ready_o = 1
  - in-flight micro-ops and open chains are discarded
- Tree data registers need no reset.

## Structure
- cellrv32_package holds:
  - rdc_op_e, the 3-bit op enum matching funct6[2:0]
  - localparams RDC_OP_SUM through RDC_OP_MAX
  - the identity-value function, written generically with DATA_WIDTH passed in
- One sub-module, vex_rdc_alu: combinational two-operand combine by op. It is instantiated per tree node and once for the accumulator.
- Levels are built with a generate loop over k=1..S. No lane-count-specific code is allowed.

## Test plan
All scenarios use VECTOR_LANES=8, DATA_WIDTH=32.
- Sum: op=0, data 1..8, mask 0xFF, seed 10, head=end=1, dst 5 → valid_o at t+4, result 46, dst_o 5.
- Signed min with mask: op=5, data {-5,3,7,2,9,4,1,6}, mask 0xFE, seed 100 → result 1. Same input with op=4 and mask 0xFF → result 1. With op=6 → result 0xFFFF_FFFB.
- All masked: op=1, mask 0x00, seed 0x1234 → result 0x1234. op=7, mask 0x00, seed -3 → result -3.
- Multi micro-op: three consecutive sum micro-ops (head; middle; end), each with data all 2, mask 0xFF, seed 1 → exactly one valid_o, result 49, at t_end+4.
- Backpressure: ready_i=0 for 3 cycles while a result is pending and two more micro-ops are offered → ready_o=0 throughout, result_o stable, results then delivered in order with none lost or duplicated.
- Reset mid-operation: rst=1 for one cycle two cycles after accept → valid_o stays 0 and busy_o=0 after reset. A new head micro-op afterwards yields the correct seeded result.
